key_conditioner: RTL and testbench

- Parametrised front end for the board push-buttons (Run, Continue and any further keys) that drive the SLC-3 top level.
- Each of N_KEYS independent channels does three things:
  - synchronises a raw active-low key;
  - debounces both press and release;
  - produces a clean level plus single-cycle press/release strobes, with optional per-channel auto-repeat.
- Sits between the key pins and the CPU control FSM, replacing ad-hoc per-button sync logic.

---
 rtl/key_conditioner.sv | 226 ++++++++++++++++++++++
 tb/tb_key_conditioner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: push-button front end for the SLC-3 top level.
//
// Each of N_KEYS channels synchronises a raw active-low key and debounces
// both press and release. It produces a clean pressed level plus one-cycle
// press and release strobes. While the key is held, and if that channel's
// auto-repeat is enabled, it also produces repeat press strobes.
//
// Ports:
//   Clk           system clock
//   Reset_n       asynchronous active-low reset
//   Key_n         raw active-low keys, asynchronous to Clk
//   Repeat_En     per-channel auto-repeat enable, synchronous to Clk
//   Level         debounced pressed state (1 = pressed), registered
//   Press_Pulse   one-cycle strobe on accepted press and on each repeat
//   Release_Pulse one-cycle strobe on accepted release
//   Any_Level     OR of Level (combinational from registered Level)
//
// Channel FSM:
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | key released and accepted as released
//   PRESS_DB | key seen low, counting stable low samples
//   HELD     | press accepted; auto-repeat timer runs here only
//   REL_DB   | key seen high, counting stable high samples; repeat frozen
module key_conditioner #(
    parameter int N_KEYS          = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [N_KEYS-1:0] Key_n,
    input  logic [N_KEYS-1:0] Repeat_En,
    output logic [N_KEYS-1:0] Level,
    output logic [N_KEYS-1:0] Press_Pulse,
    output logic [N_KEYS-1:0] Release_Pulse,
    output logic              Any_Level
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_TARGET  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RATE   = RPT_W'(REPEAT_RATE);
    localparam logic [RPT_W-1:0] RPT_SAT    = RPT_W'(RPT_MAX);

    if (N_KEYS < 1) begin : g_bad_nkeys
        $error("key_conditioner: N_KEYS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("key_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("key_conditioner: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("key_conditioner: REPEAT_RATE must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q   [N_KEYS];
    logic [SYNC_STAGES-1:0] sync_d   [N_KEYS];
    state_e                 state_q  [N_KEYS];
    state_e                 state_d  [N_KEYS];
    logic [DB_W-1:0]        dbcnt_q  [N_KEYS];
    logic [DB_W-1:0]        dbcnt_d  [N_KEYS];
    logic [RPT_W-1:0]       rptcnt_q [N_KEYS];
    logic [RPT_W-1:0]       rptcnt_d [N_KEYS];

    // 0 = waiting out REPEAT_DELAY, 1 = repeating every REPEAT_RATE
    logic [N_KEYS-1:0] rpt_phase_q, rpt_phase_d;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;

    logic [N_KEYS-1:0] key_down;
    logic [DB_W-1:0]   db_inc     [N_KEYS];
    logic [RPT_W-1:0]  rpt_inc    [N_KEYS];
    logic [RPT_W-1:0]  rpt_target [N_KEYS];

    // Synchroniser shift and saturating counter increments.
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            sync_d[i]     = {sync_q[i][SYNC_STAGES-2:0], Key_n[i]};
            key_down[i]   = ~sync_q[i][SYNC_STAGES-1];
            db_inc[i]     = (dbcnt_q[i] >= DB_TARGET) ? DB_TARGET : dbcnt_q[i] + DB_W'(1);
            rpt_inc[i]    = (rptcnt_q[i] >= RPT_SAT) ? RPT_SAT : rptcnt_q[i] + RPT_W'(1);
            rpt_target[i] = rpt_phase_q[i] ? RPT_RATE : RPT_DELAY;
        end
    end

    always_comb begin
        level_d     = level_q;
        rpt_phase_d = rpt_phase_q;
        press_d     = '0;
        release_d   = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i]  = state_q[i];
            dbcnt_d[i]  = dbcnt_q[i];
            rptcnt_d[i] = rptcnt_q[i];

            case (state_q[i])
                IDLE: begin
                    if (key_down[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d[i]     = HELD;
                            dbcnt_d[i]     = '0;
                            rptcnt_d[i]    = '0;
                            rpt_phase_d[i] = 1'b0;
                            level_d[i]     = 1'b1;
                            press_d[i]     = 1'b1;
                        end else begin
                            state_d[i] = PRESS_DB;
                            dbcnt_d[i] = DB_W'(1);
                        end
                    end
                end

                PRESS_DB: begin
                    if (!key_down[i]) begin
                        state_d[i] = IDLE;
                        dbcnt_d[i] = '0;
                    end else if (db_inc[i] == DB_TARGET) begin
                        state_d[i]     = HELD;
                        dbcnt_d[i]     = '0;
                        rptcnt_d[i]    = '0;
                        rpt_phase_d[i] = 1'b0;
                        level_d[i]     = 1'b1;
                        press_d[i]     = 1'b1;
                    end else begin
                        dbcnt_d[i] = db_inc[i];
                    end
                end

                HELD: begin
                    // A key-high sample takes priority over a due repeat, so a
                    // release in progress never emits a stray press strobe.
                    if (!key_down[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d[i]   = IDLE;
                            dbcnt_d[i]   = '0;
                            level_d[i]   = 1'b0;
                            release_d[i] = 1'b1;
                        end else begin
                            state_d[i] = REL_DB;
                            dbcnt_d[i] = DB_W'(1);
                        end
                    end else if (!Repeat_En[i]) begin
                        rptcnt_d[i]    = '0;
                        rpt_phase_d[i] = 1'b0;
                    end else if (rpt_inc[i] == rpt_target[i]) begin
                        rptcnt_d[i]    = '0;
                        rpt_phase_d[i] = 1'b1;
                        press_d[i]     = 1'b1;
                    end else begin
                        rptcnt_d[i] = rpt_inc[i];
                    end
                end

                REL_DB: begin
                    if (key_down[i]) begin
                        state_d[i] = HELD;
                        dbcnt_d[i] = '0;
                    end else if (db_inc[i] == DB_TARGET) begin
                        state_d[i]   = IDLE;
                        dbcnt_d[i]   = '0;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        dbcnt_d[i] = db_inc[i];
                    end
                end

                default: begin
                    state_d[i] = IDLE;
                    dbcnt_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_KEYS; i++) begin
                sync_q[i]   <= '1;
                state_q[i]  <= IDLE;
                dbcnt_q[i]  <= '0;
                rptcnt_q[i] <= '0;
            end
            rpt_phase_q <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                sync_q[i]   <= sync_d[i];
                state_q[i]  <= state_d[i];
                dbcnt_q[i]  <= dbcnt_d[i];
                rptcnt_q[i] <= rptcnt_d[i];
            end
            rpt_phase_q <= rpt_phase_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign Level         = level_q;
    assign Press_Pulse   = press_q;
    assign Release_Pulse = release_q;
    assign Any_Level     = |level_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed bench for key_conditioner with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, two channels.
// Edge k=0 is the first clock edge that samples a new Key_n value;
// outputs are sampled 1 time unit after each rising edge.
module tb_key_conditioner;

    logic       Clk;
    logic       Reset_n;
    logic [1:0] Key_n;
    logic [1:0] Repeat_En;
    logic [1:0] Level;
    logic [1:0] Press_Pulse;
    logic [1:0] Release_Pulse;
    logic       Any_Level;

    int n_checks = 0;
    int n_fail   = 0;

    key_conditioner #(
        .N_KEYS          (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3)
    ) u_dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Key_n         (Key_n),
        .Repeat_En     (Repeat_En),
        .Level         (Level),
        .Press_Pulse   (Press_Pulse),
        .Release_Pulse (Release_Pulse),
        .Any_Level     (Any_Level)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Press pulse schedule for the repeat test: initial pulse at 5, repeats
    // at +10 then every 3, enable dropped for edge 28, re-enabled for edge 41.
    function automatic logic rpt_exp(input int k);
        case (k)
            5, 15, 18, 21, 24, 27, 50, 53: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // Bounce pattern on key 0: low 3, high 1, low 3, then high.
    function automatic logic bounce_key(input int k);
        if (k < 3)      return 1'b0;
        else if (k == 3) return 1'b1;
        else if (k < 7)  return 1'b0;
        else             return 1'b1;
    endfunction

    initial begin
        Reset_n   = 1'b0;
        Key_n     = 2'b11;
        Repeat_En = 2'b00;

        // Reset held for 3 cycles
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst level k=%0d", k), 32'(Level), 32'd0);
            check($sformatf("rst press k=%0d", k), 32'(Press_Pulse), 32'd0);
            check($sformatf("rst release k=%0d", k), 32'(Release_Pulse), 32'd0);
            check($sformatf("rst any k=%0d", k), 32'(Any_Level), 32'd0);
        end
        Reset_n = 1'b1;
        tick();

        // Clean press on key 0
        Key_n = 2'b10;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("press pulse k=%0d", k), 32'(Press_Pulse), (k == 5) ? 32'd1 : 32'd0);
            check($sformatf("press level k=%0d", k), 32'(Level), (k >= 5) ? 32'd1 : 32'd0);
            check($sformatf("press any k=%0d", k), 32'(Any_Level), (k >= 5) ? 32'd1 : 32'd0);
        end
        for (int k = 8; k < 20; k++) begin
            tick();
            check($sformatf("held no repeat k=%0d", k), 32'(Press_Pulse), 32'd0);
            check($sformatf("held level k=%0d", k), 32'(Level), 32'd1);
        end

        // Two-cycle release glitch while held
        Key_n[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("glitch level k=%0d", k), 32'(Level), 32'd1);
            check($sformatf("glitch release k=%0d", k), 32'(Release_Pulse), 32'd0);
            if (k == 1) Key_n[0] = 1'b0;
        end

        // Clean release
        Key_n[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("release pulse k=%0d", k), 32'(Release_Pulse), (k == 5) ? 32'd1 : 32'd0);
            check($sformatf("release level k=%0d", k), 32'(Level), (k < 5) ? 32'd1 : 32'd0);
            check($sformatf("release press k=%0d", k), 32'(Press_Pulse), 32'd0);
        end

        // Bounce rejection
        Key_n[0] = bounce_key(0);
        for (int k = 0; k < 15; k++) begin
            tick();
            check($sformatf("bounce press k=%0d", k), 32'(Press_Pulse), 32'd0);
            check($sformatf("bounce level k=%0d", k), 32'(Level), 32'd0);
            Key_n[0] = bounce_key(k + 1);
        end

        // Auto-repeat, enable toggling, then release aligned to a due repeat
        Repeat_En = 2'b01;
        Key_n[0]  = 1'b0;
        for (int k = 0; k < 63; k++) begin
            tick();
            check($sformatf("rpt press k=%0d", k), 32'(Press_Pulse), 32'(rpt_exp(k)));
            check($sformatf("rpt release k=%0d", k), 32'(Release_Pulse), (k == 59) ? 32'd1 : 32'd0);
            check($sformatf("rpt level k=%0d", k), 32'(Level), (k >= 5 && k < 59) ? 32'd1 : 32'd0);
            if (k == 27) Repeat_En[0] = 1'b0;
            if (k == 40) Repeat_En[0] = 1'b1;
            if (k == 53) Key_n[0] = 1'b1;
        end
        Repeat_En = 2'b00;

        // Both keys pressed, reset pulsed during PRESS_DB
        Key_n = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("pre-abort level k=%0d", k), 32'(Level), 32'd0);
        end
        Reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort press k=%0d", k), 32'(Press_Pulse), 32'd0);
            check($sformatf("abort level k=%0d", k), 32'(Level), 32'd0);
            tick();
        end
        Reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("dual level k=%0d", k), 32'(Level), (k >= 5) ? 32'd3 : 32'd0);
            check($sformatf("dual press k=%0d", k), 32'(Press_Pulse), (k == 5) ? 32'd3 : 32'd0);
        end

        // Release key 1 only; key 0 stays held
        Key_n = 2'b10;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("indep level k=%0d", k), 32'(Level), (k >= 5) ? 32'd1 : 32'd3);
            check($sformatf("indep release k=%0d", k), 32'(Release_Pulse), (k == 5) ? 32'd2 : 32'd0);
            check($sformatf("indep any k=%0d", k), 32'(Any_Level), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
